// File: rtl/pad_frame.sv
// Chip I/O frame: serialises DW-bit core words onto PW data pads per direction,
// with a strobe on beat 0, and generates the core reset (async assert, sync release).
module pad_frame #(
  parameter int DW          = 8,
  parameter int PW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] pad_x,
  input  logic          pad_xs,
  output logic [PW-1:0] pad_y,
  output logic          pad_ys,
  output logic          die_clk,
  output logic          die_reset,
  output logic [DW-1:0] die_x,
  output logic          die_xv,
  output logic          die_xerr,
  input  logic [DW-1:0] die_y,
  input  logic          die_yv,
  output logic          die_yrdy
);

  localparam int BEATS = DW / PW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic { RX_IDLE, RX_COLLECT } rx_state_e;
  typedef enum logic { TX_IDLE, TX_SEND }    tx_state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PW-1:0]          xr_q;
  logic                   xsr_q;

  rx_state_e              rx_q, rx_d;
  logic [CW-1:0]          rcnt_q, rcnt_d;
  logic [DW-1:0]          acc_q, acc_d;
  logic [DW-1:0]          die_x_q, die_x_d;
  logic                   die_xv_q, die_xv_d;
  logic                   die_xerr_q, die_xerr_d;

  tx_state_e              tx_q, tx_d;
  logic [CW-1:0]          tcnt_q, tcnt_d;
  logic [DW-1:0]          sh_q, sh_d;
  logic [PW-1:0]          pad_y_q, pad_y_d;
  logic                   pad_ys_q, pad_ys_d;
  logic                   accept;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

  // Deserialiser: a strobe always starts a fresh frame, aborting any partial one.
  always_comb begin
    rx_d       = rx_q;
    rcnt_d     = rcnt_q;
    acc_d      = acc_q;
    die_x_d    = die_x_q;
    die_xv_d   = 1'b0;
    die_xerr_d = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        if (xsr_q) begin
          acc_d          = '0;
          acc_d[PW-1:0]  = xr_q;
          if (BEATS == 1) begin
            die_x_d  = acc_d;
            die_xv_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = CW'(1);
            rx_d   = RX_COLLECT;
          end
        end
      end
      RX_COLLECT: begin
        if (xsr_q) begin
          die_xerr_d    = 1'b1;
          acc_d         = '0;
          acc_d[PW-1:0] = xr_q;
          rcnt_d        = CW'(1);
        end else begin
          acc_d[int'(rcnt_q)*PW +: PW] = xr_q;
          if (rcnt_q == LAST) begin
            die_x_d  = acc_d;
            die_xv_d = 1'b1;
            rcnt_d   = '0;
            rx_d     = RX_IDLE;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  assign die_yrdy = (tx_q == TX_IDLE) || ((tx_q == TX_SEND) && (tcnt_q == LAST));
  assign accept   = die_yv && die_yrdy;

  // Serialiser: a word accepted on the last beat follows with no idle gap.
  always_comb begin
    tx_d     = tx_q;
    tcnt_d   = tcnt_q;
    sh_d     = sh_q;
    pad_y_d  = pad_y_q;
    pad_ys_d = 1'b0;
    if (accept) begin
      sh_d     = die_y;
      pad_y_d  = die_y[PW-1:0];
      pad_ys_d = 1'b1;
      tcnt_d   = '0;
      tx_d     = TX_SEND;
    end else if ((tx_q == TX_SEND) && (tcnt_q != LAST)) begin
      tcnt_d  = tcnt_q + CW'(1);
      pad_y_d = sh_q[(int'(tcnt_q) + 1)*PW +: PW];
    end else begin
      tcnt_d  = '0;
      pad_y_d = '0;
      tx_d    = TX_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      xr_q       <= '0;
      xsr_q      <= 1'b0;
      rx_q       <= RX_IDLE;
      rcnt_q     <= '0;
      acc_q      <= '0;
      die_x_q    <= '0;
      die_xv_q   <= 1'b0;
      die_xerr_q <= 1'b0;
      tx_q       <= TX_IDLE;
      tcnt_q     <= '0;
      sh_q       <= '0;
      pad_y_q    <= '0;
      pad_ys_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      xr_q       <= pad_x;
      xsr_q      <= pad_xs;
      rx_q       <= rx_d;
      rcnt_q     <= rcnt_d;
      acc_q      <= acc_d;
      die_x_q    <= die_x_d;
      die_xv_q   <= die_xv_d;
      die_xerr_q <= die_xerr_d;
      tx_q       <= tx_d;
      tcnt_q     <= tcnt_d;
      sh_q       <= sh_d;
      pad_y_q    <= pad_y_d;
      pad_ys_q   <= pad_ys_d;
    end
  end

  assign die_clk   = clk;
  assign die_reset = sync_q[SYNC_STAGES-1];
  assign die_x     = die_x_q;
  assign die_xv    = die_xv_q;
  assign die_xerr  = die_xerr_q;
  assign pad_y     = pad_y_q;
  assign pad_ys    = pad_ys_q;

endmodule

// File: tb/tb_pad_frame.sv
// Bench for pad_frame: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pad_frame;

  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int SYNC  = 2;
  localparam int BEATS = DW / PW;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pad_x;
  logic          pad_xs;
  logic [PW-1:0] pad_y;
  logic          pad_ys;
  logic          die_clk;
  logic          die_reset;
  logic [DW-1:0] die_x;
  logic          die_xv;
  logic          die_xerr;
  logic [DW-1:0] die_y;
  logic          die_yv;
  logic          die_yrdy;

  int checks = 0;
  int errors = 0;

  pad_frame #(.DW(DW), .PW(PW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .pad_x(pad_x), .pad_xs(pad_xs),
    .pad_y(pad_y), .pad_ys(pad_ys), .die_clk(die_clk), .die_reset(die_reset),
    .die_x(die_x), .die_xv(die_xv), .die_xerr(die_xerr),
    .die_y(die_y), .die_yv(die_yv), .die_yrdy(die_yrdy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [PW-1:0] x, input logic xs,
                               input logic [DW-1:0] y, input logic yv);
    pad_x  = x;
    pad_xs = xs;
    die_y  = y;
    die_yv = yv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: input beats since the last strobe, and a queue of pad beats still to emit.
  logic [PW-1:0] mx_r;
  logic          mxs_r;
  logic [PW-1:0] beats[$];
  logic [PW:0]   pend[$];
  logic [DW-1:0] exp_x;
  logic          exp_xv, exp_xerr;
  logic [PW-1:0] exp_pad_y;
  logic          exp_pad_ys, exp_yrdy;
  int            rst_cnt;

  always @(posedge clk) begin
    logic [DW-1:0] w;
    logic [PW:0]   e;
    if (!reset) begin
      mx_r = '0; mxs_r = 1'b0;
      beats.delete(); pend.delete();
      exp_x = '0; exp_xv = 1'b0; exp_xerr = 1'b0;
      exp_pad_y = '0; exp_pad_ys = 1'b0; exp_yrdy = 1'b1;
      rst_cnt = 0;
    end else begin
      if (rst_cnt < 100) rst_cnt++;
      exp_xv = 1'b0;
      exp_xerr = 1'b0;
      if (mxs_r) begin
        if (beats.size() > 0) exp_xerr = 1'b1;
        beats.delete();
        beats.push_back(mx_r);
      end else if (beats.size() > 0) begin
        beats.push_back(mx_r);
      end
      if (beats.size() == BEATS) begin
        w = '0;
        for (int i = 0; i < BEATS; i++) w[i*PW +: PW] = beats[i];
        exp_x = w;
        exp_xv = 1'b1;
        beats.delete();
      end
      mx_r = pad_x;
      mxs_r = pad_xs;

      if (die_yv && pend.size() == 0) begin
        w = die_y;
        for (int i = 0; i < BEATS; i++) pend.push_back({(i == 0), w[i*PW +: PW]});
      end
      if (pend.size() > 0) begin
        e = pend.pop_front();
        exp_pad_y = e[PW-1:0];
        exp_pad_ys = e[PW];
      end else begin
        exp_pad_y = '0;
        exp_pad_ys = 1'b0;
      end
      exp_yrdy = (pend.size() == 0);
    end
  end

  always @(negedge clk) begin
    checkOutput("die_clk", 32'(die_clk), 32'(clk));
    if (!reset) begin
      checkOutput("rst_pad_y", 32'(pad_y), 32'h0);
      checkOutput("rst_pad_ys", 32'(pad_ys), 32'h0);
      checkOutput("rst_die_x", 32'(die_x), 32'h0);
      checkOutput("rst_die_xv", 32'(die_xv), 32'h0);
      checkOutput("rst_die_xerr", 32'(die_xerr), 32'h0);
      checkOutput("rst_die_reset", 32'(die_reset), 32'h0);
    end else begin
      checkOutput("pad_y", 32'(pad_y), 32'(exp_pad_y));
      checkOutput("pad_ys", 32'(pad_ys), 32'(exp_pad_ys));
      checkOutput("die_x", 32'(die_x), 32'(exp_x));
      checkOutput("die_xv", 32'(die_xv), 32'(exp_xv));
      checkOutput("die_xerr", 32'(die_xerr), 32'(exp_xerr));
      checkOutput("die_yrdy", 32'(die_yrdy), 32'(exp_yrdy));
      checkOutput("die_reset", 32'(die_reset), 32'(rst_cnt >= SYNC));
    end
  end

  initial begin
    reset = 1'b0;
    applyStimulus('0, 1'b0, '0, 1'b0);

    // Reset held with pads toggling, then release and watch the synchroniser.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
    end
    @(negedge clk);
    checkOutput("lit_rst_die_x", 32'(die_x), 32'h0);
    checkOutput("lit_rst_pad_y", 32'(pad_y), 32'h0);
    tick();
    reset = 1'b1;
    applyStimulus('0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("lit_rel_die_reset0", 32'(die_reset), 32'h0);
    checkOutput("lit_rel_yrdy", 32'(die_yrdy), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit_rel_die_reset1", 32'(die_reset), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("lit_rel_die_reset2", 32'(die_reset), 32'h1);
    tick(); tick();

    // Input frame 0xA5.
    applyStimulus(4'h5, 1'b1, '0, 1'b0); tick();
    applyStimulus(4'hA, 1'b0, '0, 1'b0); tick();
    applyStimulus(4'h0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("lit_in_xv_c2", 32'(die_xv), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("lit_in_x", 32'(die_x), 32'hA5);
    checkOutput("lit_in_xv_c3", 32'(die_xv), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit_in_xv_c4", 32'(die_xv), 32'h0);
    checkOutput("lit_in_hold", 32'(die_x), 32'hA5);
    tick();

    // Abort: strobe, strobe, data.
    applyStimulus(4'h3, 1'b1, '0, 1'b0); tick();
    applyStimulus(4'h4, 1'b1, '0, 1'b0); tick();
    applyStimulus(4'h6, 1'b0, '0, 1'b0); tick();
    applyStimulus(4'h0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("lit_ab_xerr", 32'(die_xerr), 32'h1);
    checkOutput("lit_ab_xv0", 32'(die_xv), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("lit_ab_x", 32'(die_x), 32'h64);
    checkOutput("lit_ab_xv1", 32'(die_xv), 32'h1);
    checkOutput("lit_ab_xerr0", 32'(die_xerr), 32'h0);
    tick(); tick();

    // Single output word 0xC3.
    applyStimulus('0, 1'b0, 8'hC3, 1'b1); tick();
    applyStimulus('0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_out_b0", 32'({pad_ys, pad_y}), 32'h13);
    checkOutput("lit_out_rdy1", 32'(die_yrdy), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("lit_out_b1", 32'({pad_ys, pad_y}), 32'h0C);
    checkOutput("lit_out_rdy2", 32'(die_yrdy), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("lit_out_idle", 32'({pad_ys, pad_y}), 32'h00);
    tick();

    // Back-to-back 0x12 then 0x34.
    applyStimulus('0, 1'b0, 8'h12, 1'b1); tick();
    applyStimulus('0, 1'b0, 8'h34, 1'b1);
    @(negedge clk);
    checkOutput("lit_b2b_0", 32'({pad_ys, pad_y}), 32'h12);
    tick();
    @(negedge clk);
    checkOutput("lit_b2b_1", 32'({pad_ys, pad_y}), 32'h01);
    tick();
    applyStimulus('0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_b2b_2", 32'({pad_ys, pad_y}), 32'h14);
    tick();
    @(negedge clk);
    checkOutput("lit_b2b_3", 32'({pad_ys, pad_y}), 32'h03);
    tick(); tick();

    // Reset mid-frame in both directions, then a fresh 0x5A frame.
    applyStimulus(4'h5, 1'b1, 8'h77, 1'b1); tick();
    applyStimulus(4'hA, 1'b0, 8'h00, 1'b0); tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("lit_mid_pad_y", 32'({pad_ys, pad_y}), 32'h00);
    tick();
    @(negedge clk);
    checkOutput("lit_mid_xv", 32'(die_xv), 32'h0);
    tick();
    reset = 1'b1;
    applyStimulus(4'hA, 1'b1, '0, 1'b0); tick();
    applyStimulus(4'h5, 1'b0, '0, 1'b0); tick();
    applyStimulus(4'h0, 1'b0, '0, 1'b0); tick();
    @(negedge clk);
    checkOutput("lit_mid_x", 32'(die_x), 32'h5A);
    checkOutput("lit_mid_xv1", 32'(die_xv), 32'h1);
    tick();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1;
    applyStimulus('0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
